// File: rtl/hwregs_arbiter_if.sv
// Single-master port of the hardware register arbiter.
// Request/payload from the master, ready and read response back.
interface hwregs_arbiter_if;
    logic        request;
    logic        write;
    logic [15:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        lock;
    logic        ready;
    logic        rvalid;
    logic [8:0]  rtag;
    logic [31:0] rdata;

    modport master (
        output request,
        output write,
        output addr,
        output wmask,
        output wdata,
        output lock,
        input  ready,
        input  rvalid,
        input  rtag,
        input  rdata
    );

    modport slave (
        input  request,
        input  write,
        input  addr,
        input  wmask,
        input  wdata,
        input  lock,
        output ready,
        output rvalid,
        output rtag,
        output rdata
    );
endinterface

// File: rtl/hwregs_arbiter.sv
// Two-master arbiter (CPU, debug monitor) in front of the hw register block.
// Round-robin with optional bus lock, lock idle timeout and read routing.
module hwregs_arbiter #(
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    hwregs_arbiter_if.slave m0,
    hwregs_arbiter_if.slave m1,
    output logic            hw_request,
    output logic            hw_write,
    output logic [15:0]     hw_addr,
    output logic [3:0]      hw_wmask,
    output logic [31:0]     hw_wdata,
    input  logic            hw_rvalid,
    input  logic [8:0]      hw_rtag,
    input  logic [31:0]     hw_rdata,
    output logic            lock_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    // Value of the idle counter on the last idle cycle before release.
    localparam logic [6:0] TO_LAST = 7'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [6:0]  idle_q, idle_d;
    logic        gnt0, gnt1;
    logic        acc0, acc1;
    logic        timeout;

    logic        req_q;
    logic        write_q;
    logic [15:0] addr_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic        own_q;
    logic        pend_q;
    logic        pend_own_q;

    // Grant selection, lock tracking and idle timeout.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        timeout = 1'b0;
        state_d = state_q;
        ptr_d   = ptr_q;
        idle_d  = idle_q;
        unique case (state_q)
            IDLE: begin
                gnt0   = m0.request & (~m1.request | ~ptr_q);
                gnt1   = m1.request & (~m0.request | ptr_q);
                idle_d = '0;
                if (gnt0) begin
                    ptr_d = 1'b1;
                    if (m0.lock) state_d = LOCK0;
                end else if (gnt1) begin
                    ptr_d = 1'b0;
                    if (m1.lock) state_d = LOCK1;
                end
            end
            LOCK0: begin
                gnt0 = m0.request;
                if (m0.request) begin
                    idle_d = '0;
                    if (!m0.lock) begin
                        state_d = IDLE;
                        ptr_d   = 1'b1;
                    end
                end else if (idle_q == TO_LAST) begin
                    timeout = 1'b1;
                    idle_d  = '0;
                    state_d = IDLE;
                end else begin
                    idle_d = idle_q + 7'd1;
                end
            end
            LOCK1: begin
                gnt1 = m1.request;
                if (m1.request) begin
                    idle_d = '0;
                    if (!m1.lock) begin
                        state_d = IDLE;
                        ptr_d   = 1'b0;
                    end
                end else if (idle_q == TO_LAST) begin
                    timeout = 1'b1;
                    idle_d  = '0;
                    state_d = IDLE;
                end else begin
                    idle_d = idle_q + 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Nothing is accepted while reset is held, even though reset is synchronous.
    assign acc0         = gnt0 & ~reset;
    assign acc1         = gnt1 & ~reset;
    assign m0.ready     = acc0;
    assign m1.ready     = acc1;
    assign lock_timeout = timeout & ~reset;

    // Arbitration state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
        end
    end

    // Downstream request register; owner travels with the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            own_q   <= 1'b0;
        end else begin
            req_q <= acc0 | acc1;
            if (acc0) begin
                write_q <= m0.write;
                addr_q  <= m0.addr;
                wmask_q <= m0.wmask;
                wdata_q <= m0.wdata;
                own_q   <= 1'b0;
            end else if (acc1) begin
                write_q <= m1.write;
                addr_q  <= m1.addr;
                wmask_q <= m1.wmask;
                wdata_q <= m1.wdata;
                own_q   <= 1'b1;
            end
        end
    end

    // Remember whether last cycle carried a read, and whose it was.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_own_q <= 1'b0;
        end else begin
            pend_q     <= req_q & ~write_q;
            pend_own_q <= own_q;
        end
    end

    assign hw_request = req_q & ~reset;
    assign hw_write   = write_q;
    assign hw_addr    = addr_q;
    assign hw_wmask   = wmask_q;
    assign hw_wdata   = wdata_q;

    assign m0.rvalid = hw_rvalid & pend_q & ~pend_own_q & ~reset;
    assign m1.rvalid = hw_rvalid & pend_q & pend_own_q & ~reset;
    assign m0.rtag   = hw_rtag;
    assign m1.rtag   = hw_rtag;
    assign m0.rdata  = hw_rdata;
    assign m1.rdata  = hw_rdata;

endmodule
